// File: rtl/mini_alu_stack_core_pkg.sv
// Shared opcode and instruction-field definitions
// for the mini ALU stack core.
package mini_alu_stack_core_pkg;

  localparam int InstrWidth = 28;

  localparam int OpMsb  = 27;
  localparam int OpLsb  = 24;
  localparam int DstMsb = 23;
  localparam int DstLsb = 16;
  localparam int S1Msb  = 15;
  localparam int S1Lsb  = 8;
  localparam int S0Msb  = 7;
  localparam int S0Lsb  = 0;

  typedef enum logic [3:0] {
    OpNop  = 4'd0,
    OpSto  = 4'd1,
    OpAdd  = 4'd2,
    OpSub  = 4'd3,
    OpInc  = 4'd4,
    OpDec  = 4'd5,
    OpJmp  = 4'd6,
    OpBle  = 4'd7,
    OpBge  = 4'd8,
    OpCall = 4'd9,
    OpRet  = 4'd10,
    OpVga  = 4'd11,
    OpHalt = 4'd12
  } opcodeT;

  localparam logic [InstrWidth-1:0] NopWord =
    {OpNop, 24'h0};

endpackage

// File: rtl/mini_alu_stack_core_return_stack.sv
// LIFO of return addresses; push/pop are ignored
// when full/empty so the caller can flag the fault.
module mini_alu_stack_core_return_stack #(
  parameter int ADDR_WIDTH  = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          iPush,
  input  logic                          iPop,
  input  logic [ADDR_WIDTH-1:0]         iData,
  output logic [ADDR_WIDTH-1:0]         oTop,
  output logic                          oFull,
  output logic                          oEmpty,
  output logic [$clog2(STACK_DEPTH):0]  oLevel
);

  localparam int PtrW = $clog2(STACK_DEPTH);

  logic [ADDR_WIDTH-1:0] mem [STACK_DEPTH];
  logic [PtrW:0]         sp;
  logic [PtrW-1:0]       topIdx;

  assign oFull  = (sp == (PtrW+1)'(STACK_DEPTH));
  assign oEmpty = (sp == '0);
  assign topIdx = PtrW'(sp - 1'b1);
  assign oTop   = mem[topIdx];
  assign oLevel = sp;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sp <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (iPush && !oFull) begin
      mem[sp[PtrW-1:0]] <= iData;
      sp <= sp + 1'b1;
    end else if (iPop && !oEmpty) begin
      sp <= sp - 1'b1;
    end
  end

endmodule

// File: rtl/mini_alu_stack_core.sv
// Two-stage (fetch/execute) mini core with register
// file, return stack and VGA pixel-write port.
module mini_alu_stack_core
  import mini_alu_stack_core_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int REG_COUNT   = 8,
  parameter int STACK_DEPTH = 4,
  parameter int COORD_WIDTH = 8,
  parameter int COLOR_WIDTH = 3
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          iEnable,
  output logic [ADDR_WIDTH-1:0]         oIP,
  input  logic [InstrWidth-1:0]         iInstruction,
  output logic                          oVGAWriteEnable,
  output logic [2*COORD_WIDTH-1:0]      oVGAAddress,
  output logic [COLOR_WIDTH-1:0]        oVGAColor,
  output logic                          oHalted,
  output logic                          oStackFault,
  output logic [$clog2(STACK_DEPTH):0]  oStackLevel
);

  localparam int IdxW = $clog2(REG_COUNT);

  logic [ADDR_WIDTH-1:0] ipReg;
  logic [ADDR_WIDTH-1:0] target;
  logic [ADDR_WIDTH-1:0] stackTop;
  logic [InstrWidth-1:0] decodeReg;
  logic [DATA_WIDTH-1:0] regFile [REG_COUNT];
  logic [DATA_WIDTH-1:0] opA;
  logic [DATA_WIDTH-1:0] opB;
  logic [DATA_WIDTH-1:0] wrData;
  logic [3:0]            op;
  logic [7:0]            dst;
  logic [7:0]            src1;
  logic [7:0]            src0;
  logic halted;
  logic stackFault;
  logic active;
  logic wrEn;
  logic taken;
  logic push;
  logic pop;
  logic fault;
  logic vga;
  logic doHalt;
  logic stackFull;
  logic stackEmpty;
  logic isSto, isAdd, isSub, isInc, isDec;
  logic isJmp, isBle, isBge, isCall, isRet;
  logic isVga, isHalt;

  assign op   = decodeReg[OpMsb:OpLsb];
  assign dst  = decodeReg[DstMsb:DstLsb];
  assign src1 = decodeReg[S1Msb:S1Lsb];
  assign src0 = decodeReg[S0Msb:S0Lsb];

  assign opA = regFile[src1[IdxW-1:0]];
  assign opB = regFile[src0[IdxW-1:0]];

  // Halt overrides the enable input entirely.
  assign active = iEnable && !halted;

  assign isSto  = (op == OpSto);
  assign isAdd  = (op == OpAdd);
  assign isSub  = (op == OpSub);
  assign isInc  = (op == OpInc);
  assign isDec  = (op == OpDec);
  assign isJmp  = (op == OpJmp);
  assign isBle  = (op == OpBle);
  assign isBge  = (op == OpBge);
  assign isCall = (op == OpCall);
  assign isRet  = (op == OpRet);
  assign isVga  = (op == OpVga);
  assign isHalt = (op == OpHalt);

  always_comb begin
    wrEn   = 1'b0;
    wrData = '0;
    taken  = 1'b0;
    target = ADDR_WIDTH'(dst);
    push   = 1'b0;
    pop    = 1'b0;
    fault  = 1'b0;
    vga    = 1'b0;
    doHalt = 1'b0;
    unique case (1'b1)
      isSto: begin
        wrEn   = 1'b1;
        wrData = DATA_WIDTH'({src1, src0});
      end
      isAdd: begin
        wrEn   = 1'b1;
        wrData = opA + opB;
      end
      isSub: begin
        wrEn   = 1'b1;
        wrData = opA - opB;
      end
      isInc: begin
        wrEn   = 1'b1;
        wrData = opA + 1'b1;
      end
      isDec: begin
        wrEn   = 1'b1;
        wrData = opA - 1'b1;
      end
      isJmp:  taken = 1'b1;
      isBle:  taken = (opA <= opB);
      isBge:  taken = (opA >= opB);
      isCall: begin
        fault = stackFull;
        push  = !stackFull;
        taken = !stackFull;
      end
      isRet: begin
        fault  = stackEmpty;
        pop    = !stackEmpty;
        taken  = !stackEmpty;
        target = stackTop;
      end
      isVga:  vga = 1'b1;
      isHalt: doHalt = 1'b1;
      default: ;
    endcase
  end

  // Taken transfers steer the ROM now: zero-penalty branch.
  assign oIP = taken ? target : ipReg;

  mini_alu_stack_core_return_stack #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) uStack (
    .Clock  (Clock),
    .Reset  (Reset),
    .iPush  (push && active),
    .iPop   (pop && active),
    .iData  (ipReg),
    .oTop   (stackTop),
    .oFull  (stackFull),
    .oEmpty (stackEmpty),
    .oLevel (oStackLevel)
  );

  assign oVGAWriteEnable = vga && active;
  assign oVGAAddress = oVGAWriteEnable
    ? {opA[COORD_WIDTH-1:0], opB[COORD_WIDTH-1:0]}
    : '0;
  assign oVGAColor = oVGAWriteEnable
    ? dst[COLOR_WIDTH-1:0]
    : '0;

  assign oHalted     = halted;
  assign oStackFault = stackFault;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ipReg      <= '0;
      decodeReg  <= NopWord;
      halted     <= 1'b0;
      stackFault <= 1'b0;
    end else if (active) begin
      if (fault) begin
        stackFault <= 1'b1;
      end
      if (doHalt) begin
        halted    <= 1'b1;
        decodeReg <= NopWord;
      end else begin
        decodeReg <= iInstruction;
        ipReg     <= oIP + ADDR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regFile[i] <= '0;
      end
    end else if (active && wrEn) begin
      regFile[dst[IdxW-1:0]] <= wrData;
    end
  end

endmodule
